// File: rtl/fpalu_sequencer_pkg.sv
// Shared FP opcode constants and ALU response bundle
// for the FP issue/completion sequencer.
package fpalu_sequencer_pkg;

    localparam logic [4:0] FOPADD    = 5'd0;
    localparam logic [4:0] FOPSUB    = 5'd1;
    localparam logic [4:0] FOPMUL    = 5'd2;
    localparam logic [4:0] FOPDIV    = 5'd3;
    localparam logic [4:0] FOPSQRT   = 5'd4;
    localparam logic [4:0] FOPCEQ    = 5'd5;
    localparam logic [4:0] FOPCLT    = 5'd6;
    localparam logic [4:0] FOPCLE    = 5'd7;
    localparam logic [4:0] FOPMAX    = 5'd8;
    localparam logic [4:0] FOPMIN    = 5'd9;
    localparam logic [4:0] FOPCVTSW  = 5'd10;
    localparam logic [4:0] FOPCVTWS  = 5'd11;
    localparam logic [4:0] FOPCVTSWU = 5'd12;
    localparam logic [4:0] FOPCVTWUS = 5'd13;
    localparam logic [4:0] FOPABS    = 5'd14;
    localparam logic [4:0] FOPNEG    = 5'd15;
    localparam logic [4:0] FOPSGNJ   = 5'd16;
    localparam logic [4:0] FOPSGNJN  = 5'd17;
    localparam logic [4:0] FOPSGNJX  = 5'd18;

    typedef struct packed {
        logic [31:0] result;
        logic        nan;
        logic        zero;
        logic        overflow;
        logic        underflow;
        logic        comp;
    } alu_out_t;

endpackage

// File: rtl/fpalu_sequencer_if.sv
// Issue, ALU-drive and completion signals of the FP sequencer.
// master = pipeline/ALU side, slave = sequencer.
interface fpalu_sequencer_if;
    import fpalu_sequencer_pkg::*;

    logic        istart;
    logic        iflush;
    logic [4:0]  icontrol;
    logic [31:0] idataa;
    logic [31:0] idatab;

    logic [4:0]  ocontrol;
    logic [31:0] odataa;
    logic [31:0] odatab;

    logic [31:0] ialu_result;
    logic        ialu_nan;
    logic        ialu_zero;
    logic        ialu_overflow;
    logic        ialu_underflow;
    logic        ialu_comp;

    logic        obusy;
    logic        odone;
    logic [31:0] oresult;
    logic        onan;
    logic        ozero;
    logic        ooverflow;
    logic        ounderflow;
    logic        oCompResult;

    modport master (
        output istart, iflush, icontrol, idataa, idatab,
        output ialu_result, ialu_nan, ialu_zero,
        output ialu_overflow, ialu_underflow, ialu_comp,
        input  ocontrol, odataa, odatab,
        input  obusy, odone, oresult,
        input  onan, ozero, ooverflow, ounderflow, oCompResult
    );

    modport slave (
        input  istart, iflush, icontrol, idataa, idatab,
        input  ialu_result, ialu_nan, ialu_zero,
        input  ialu_overflow, ialu_underflow, ialu_comp,
        output ocontrol, odataa, odatab,
        output obusy, odone, oresult,
        output onan, ozero, ooverflow, ounderflow, oCompResult
    );

endinterface

// File: rtl/fpalu_latency_lut.sv
// Opcode -> ALU pipeline latency decode.
// Unlisted opcodes fall back to the combinational latency.
module fpalu_latency_lut
    import fpalu_sequencer_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 6,
    parameter int LAT_SQRT   = 16,
    parameter int LAT_CMP    = 1,
    parameter int LAT_CVT    = 6,
    parameter int LAT_COMB   = 0
) (
    input  logic [4:0]       op,
    output logic [CNT_W-1:0] lat
);

    always_comb begin
        lat = CNT_W'(LAT_COMB);
        case (op)
            FOPADD, FOPSUB:
                lat = CNT_W'(LAT_ADDSUB);
            FOPMUL:
                lat = CNT_W'(LAT_MUL);
            FOPDIV:
                lat = CNT_W'(LAT_DIV);
            FOPSQRT:
                lat = CNT_W'(LAT_SQRT);
            FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:
                lat = CNT_W'(LAT_CMP);
            FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS:
                lat = CNT_W'(LAT_CVT);
            default:
                lat = CNT_W'(LAT_COMB);
        endcase
    end

endmodule

// File: rtl/fpalu_sequencer.sv
// FP ALU issue/completion controller: holds operands for the
// opcode latency, captures the ALU response, strobes odone.
module fpalu_sequencer
    import fpalu_sequencer_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 6,
    parameter int LAT_SQRT   = 16,
    parameter int LAT_CMP    = 1,
    parameter int LAT_CVT    = 6,
    parameter int LAT_COMB   = 0
) (
    input  logic               iclock,
    input  logic               ireset,
    fpalu_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             issue;
    logic             capture;

    fpalu_latency_lut #(
        .CNT_W      (CNT_W),
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_SQRT   (LAT_SQRT),
        .LAT_CMP    (LAT_CMP),
        .LAT_CVT    (LAT_CVT),
        .LAT_COMB   (LAT_COMB)
    ) u_lut (
        .op  (bus.icontrol),
        .lat (lat)
    );

    // Flush beats start everywhere; DONE doubles as IDLE
    // so a new op can issue with no bubble.
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.istart && !bus.iflush) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.iflush) begin
                    state_d = S_IDLE;
                end else if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.istart && !bus.iflush) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.obusy = (state == S_WAIT);
    assign bus.odone = (state == S_DONE);

    always_ff @(posedge iclock) begin
        if (ireset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            bus.ocontrol    <= '0;
            bus.odataa      <= '0;
            bus.odatab      <= '0;
            bus.oresult     <= '0;
            bus.onan        <= 1'b0;
            bus.ozero       <= 1'b0;
            bus.ooverflow   <= 1'b0;
            bus.ounderflow  <= 1'b0;
            bus.oCompResult <= 1'b0;
        end else begin
            state <= state_d;
            if (issue) begin
                bus.ocontrol <= bus.icontrol;
                bus.odataa   <= bus.idataa;
                bus.odatab   <= bus.idatab;
                cnt          <= lat;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                bus.oresult     <= bus.ialu_result;
                bus.onan        <= bus.ialu_nan;
                bus.ozero       <= bus.ialu_zero;
                bus.ooverflow   <= bus.ialu_overflow;
                bus.ounderflow  <= bus.ialu_underflow;
                bus.oCompResult <= bus.ialu_comp;
            end
        end
    end

endmodule

// File: tb/tb_fpalu_sequencer.sv
// Bench for fpalu_sequencer: stub ALU, vector table,
// scoreboard queue and hand-written corner sequences.
module tb_fpalu_sequencer;
    import fpalu_sequencer_pkg::*;

    logic iclock;
    logic ireset;

    fpalu_sequencer_if bus ();

    fpalu_sequencer dut (
        .iclock (iclock),
        .ireset (ireset),
        .bus    (bus)
    );

    initial iclock = 1'b0;
    always #5 iclock = ~iclock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Stub ALU: knows only the operand pairs the bench uses.
    function automatic alu_out_t alu_model(
        logic [4:0] op, logic [31:0] a, logic [31:0] b);
        alu_out_t r;
        r = '0;
        case (op)
            FOPADD:
                if (a == 32'h3F800000 && b == 32'h40000000)
                    r.result = 32'h40400000;
            FOPSUB:
                if (a == b) r.zero = 1'b1;
            FOPMUL: begin
                if (a == 32'h40000000 && b == 32'h40400000)
                    r.result = 32'h40C00000;
                else if (a == 32'h7F000000 && b == a) begin
                    r.result   = 32'h7F800000;
                    r.overflow = 1'b1;
                end else if (a == 32'h00800000 && b == a) begin
                    r.zero      = 1'b1;
                    r.underflow = 1'b1;
                end
            end
            FOPDIV:
                if (a == 32'h40C00000 && b == 32'h40000000)
                    r.result = 32'h40400000;
            FOPSQRT: begin
                if (a == 32'h41800000)
                    r.result = 32'h40800000;
                else if (a == 32'hBF800000) begin
                    r.result = 32'h7FC00000;
                    r.nan    = 1'b1;
                end
            end
            FOPCEQ: r.comp = (a == b);
            FOPCLT: r.comp = (a < b);
            FOPCLE: r.comp = (a <= b);
            FOPMAX: r.result = (a > b) ? a : b;
            FOPMIN: r.result = (a < b) ? a : b;
            FOPCVTWS, FOPCVTWUS:
                if (a == 32'h40400000) r.result = 32'd3;
            FOPCVTSW, FOPCVTSWU:
                if (a == 32'd3) r.result = 32'h40400000;
            FOPABS:   r.result = {1'b0, a[30:0]};
            FOPNEG:   r.result = {~a[31], a[30:0]};
            FOPSGNJ:  r.result = {b[31], a[30:0]};
            FOPSGNJN: r.result = {~b[31], a[30:0]};
            FOPSGNJX: r.result = {a[31] ^ b[31], a[30:0]};
            default:  r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_out_t r;
        r = alu_model(bus.ocontrol, bus.odataa, bus.odatab);
        bus.ialu_result    = r.result;
        bus.ialu_nan       = r.nan;
        bus.ialu_zero      = r.zero;
        bus.ialu_overflow  = r.overflow;
        bus.ialu_underflow = r.underflow;
        bus.ialu_comp      = r.comp;
    end

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclock);
        #1;
    endtask

    task automatic issue(logic [4:0] op, logic [31:0] a,
                         logic [31:0] b);
        bus.icontrol = op;
        bus.idataa   = a;
        bus.idatab   = b;
        bus.istart   = 1'b1;
        tick();
        bus.istart   = 1'b0;
    endtask

    task automatic expect_op(logic [4:0] op, logic [31:0] res,
                             logic [4:0] flags, int lat);
        exp_t e;
        e.op = op; e.res = res; e.flags = flags; e.lat = lat;
        sb.push_back(e);
    endtask

    function automatic logic [4:0] out_flags();
        return {bus.onan, bus.ozero, bus.ooverflow,
                bus.ounderflow, bus.oCompResult};
    endfunction

    // n0: edges already elapsed since issue, all of them busy
    task automatic complete(string name, int n0);
        exp_t e;
        int   n;
        int   busy;
        n    = n0;
        busy = n0;
        while (!bus.odone && n < 40) begin
            if (bus.obusy) busy++;
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/sb: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, "/lat"},   n,          e.lat);
            check({name, "/busy"},  busy,       e.lat);
            check({name, "/done"},  bus.odone,  1);
            check({name, "/res"},   bus.oresult, e.res);
            check({name, "/flags"}, out_flags(), e.flags);
            check({name, "/ctl"},   bus.ocontrol, e.op);
        end
    endtask

    task automatic check_cleared(string name);
        check({name, "/busy"},  bus.obusy,    0);
        check({name, "/done"},  bus.odone,    0);
        check({name, "/res"},   bus.oresult,  0);
        check({name, "/flags"}, out_flags(),  0);
        check({name, "/ctl"},   bus.ocontrol, 0);
        check({name, "/a"},     bus.odataa,   0);
        check({name, "/b"},     bus.odatab,   0);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;

        vecs = '{
            '{FOPADD,    32'h3F800000, 32'h40000000, 32'h40400000, 5'b00000, 8},
            '{FOPSUB,    32'h3F800000, 32'h3F800000, 32'h00000000, 5'b01000, 8},
            '{FOPMUL,    32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000, 6},
            '{FOPMUL,    32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00100, 6},
            '{FOPMUL,    32'h00800000, 32'h00800000, 32'h00000000, 5'b01010, 6},
            '{FOPDIV,    32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 7},
            '{FOPSQRT,   32'hBF800000, 32'h00000000, 32'h7FC00000, 5'b10000, 17},
            '{FOPCLE,    32'h3F800000, 32'h3F800000, 32'h00000000, 5'b00001, 2},
            '{FOPCEQ,    32'h3F800000, 32'h40000000, 32'h00000000, 5'b00000, 2},
            '{FOPMAX,    32'h3F800000, 32'h40000000, 32'h40000000, 5'b00000, 2},
            '{FOPMIN,    32'h3F800000, 32'h40000000, 32'h3F800000, 5'b00000, 2},
            '{FOPCVTWS,  32'h40400000, 32'h00000000, 32'h00000003, 5'b00000, 7},
            '{FOPCVTSW,  32'h00000003, 32'h00000000, 32'h40400000, 5'b00000, 7},
            '{FOPCVTWUS, 32'h40400000, 32'h00000000, 32'h00000003, 5'b00000, 7},
            '{FOPCVTSWU, 32'h00000003, 32'h00000000, 32'h40400000, 5'b00000, 7},
            '{FOPNEG,    32'h40490FDB, 32'h00000000, 32'hC0490FDB, 5'b00000, 1},
            '{FOPABS,    32'hC0490FDB, 32'h00000000, 32'h40490FDB, 5'b00000, 1},
            '{FOPSGNJN,  32'h3F800000, 32'h3F800000, 32'hBF800000, 5'b00000, 1},
            '{FOPSGNJX,  32'hBF800000, 32'h80000000, 32'h3F800000, 5'b00000, 1},
            '{5'd31,     32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b00000, 1}
        };

        bus.istart   = 1'b0;
        bus.iflush   = 1'b0;
        bus.icontrol = '0;
        bus.idataa   = '0;
        bus.idatab   = '0;
        ireset       = 1'b1;
        tick();
        tick();
        ireset = 1'b0;
        check_cleared("reset");

        foreach (vecs[i]) begin
            expect_op(vecs[i].op, vecs[i].res,
                      vecs[i].flags, vecs[i].lat);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            complete($sformatf("vec%0d", i), 0);
            check($sformatf("vec%0d/a", i), bus.odataa, vecs[i].a);
            check($sformatf("vec%0d/b", i), bus.odatab, vecs[i].b);
            if (i % 2 == 0) tick();
        end
        tick();

        // SQRT with an ignored second start mid-WAIT
        expect_op(FOPSQRT, 32'h40800000, 5'b00000, 17);
        issue(FOPSQRT, 32'h41800000, 32'h0);
        repeat (3) tick();
        bus.icontrol = FOPADD;
        bus.idataa   = 32'h3F800000;
        bus.istart   = 1'b1;
        tick();
        bus.istart   = 1'b0;
        check("sqrt/busy", bus.obusy, 1);
        check("sqrt/ctl", bus.ocontrol, FOPSQRT);
        check("sqrt/a", bus.odataa, 32'h41800000);
        complete("sqrt", 4);
        tick();

        // MUL then CLT issued in the DONE cycle
        expect_op(FOPMUL, 32'h40C00000, 5'b00000, 6);
        issue(FOPMUL, 32'h40000000, 32'h40400000);
        complete("b2b_mul", 0);
        expect_op(FOPCLT, 32'h0, 5'b00001, 2);
        issue(FOPCLT, 32'h3F800000, 32'h40000000);
        complete("b2b_clt", 0);
        tick();

        // Flush mid-WAIT keeps previous result, no done
        expect_op(FOPNEG, 32'hC0490FDB, 5'b00000, 1);
        issue(FOPNEG, 32'h40490FDB, 32'h0);
        complete("pre_flush", 0);
        tick();
        issue(FOPDIV, 32'h40C00000, 32'h40000000);
        repeat (2) tick();
        bus.iflush = 1'b1;
        tick();
        bus.iflush = 1'b0;
        check("flush/busy", bus.obusy, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.odone || bus.obusy) seen++;
            tick();
        end
        check("flush/no_done", seen, 0);
        check("flush/res", bus.oresult, 32'hC0490FDB);
        check("flush/ctl", bus.ocontrol, FOPDIV);

        // Flush in DONE overrides a simultaneous start
        expect_op(FOPABS, 32'h40490FDB, 5'b00000, 1);
        issue(FOPABS, 32'hC0490FDB, 32'h0);
        complete("done_flush", 0);
        bus.icontrol = FOPADD;
        bus.idataa   = 32'h3F800000;
        bus.idatab   = 32'h40000000;
        bus.istart   = 1'b1;
        bus.iflush   = 1'b1;
        tick();
        bus.istart   = 1'b0;
        bus.iflush   = 1'b0;
        check("done_flush/busy", bus.obusy, 0);
        check("done_flush/done", bus.odone, 0);
        check("done_flush/ctl", bus.ocontrol, FOPABS);
        check("done_flush/res", bus.oresult, 32'h40490FDB);

        // Reset mid-WAIT of CVTWS, then SGNJ
        issue(FOPCVTWS, 32'h40400000, 32'h0);
        repeat (3) tick();
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        check_cleared("mid_reset");
        expect_op(FOPSGNJ, 32'hBF800000, 5'b00000, 1);
        issue(FOPSGNJ, 32'h3F800000, 32'h80000000);
        complete("sgnj", 0);
        tick();
        check("end/done_low", bus.odone, 0);
        check("end/sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
